simd_lane_serializer: RTL and testbench

Result-side companion to simd_alu. It captures each full-width SIMD result vector, indicated by the ALU's valid pulse, into a small vector FIFO. It then drains the vector one lane per beat over a valid/ready stream toward writeback or a debug port. Lanes are emitted in order 0..LANES-1, and each beat is tagged with its lane index, opcode and a last-lane marker.

---
 rtl/simd_lane_serializer.sv | 134 +++++++++++++
 tb/tb_simd_lane_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_lane_serializer.sv
// Buffers full-width SIMD result vectors in a small FIFO and drains them one
// lane per beat over a valid/ready stream, tagged with lane index, opcode and last marker.
module simd_lane_serializer #(
  parameter int LANES = 8,
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [LANES*WIDTH-1:0]     in_data,
  input  logic [2:0]                 in_op,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(LANES)-1:0]   out_lane,
  output logic [2:0]                 out_op,
  output logic                       out_last,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     level_q;
  logic [CW-1:0]     level_nxt;
  logic [LW-1:0]     lane_cnt;
  logic              overflow_q;
  logic              push;
  logic              drop;
  logic              beat;
  logic              lane_is_last;
  logic              last_beat;

  logic [WIDTH-1:0]  mem_data [DEPTH][LANES];
  logic [2:0]        mem_op   [DEPTH];

  // in_ready depends only on registered occupancy, so a pop in the same
  // cycle never frees a slot for the incoming vector.
  assign in_ready     = (level_q != CW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign drop         = in_valid && !in_ready;
  assign beat         = out_valid && out_ready;
  assign lane_is_last = (lane_cnt == LW'(LANES - 1));
  assign last_beat    = beat && lane_is_last;
  assign level        = level_q;
  assign overflow     = overflow_q;

  always_comb begin
    level_nxt = level_q;
    case ({push, last_beat})
      2'b10:   level_nxt = level_q + CW'(1);
      2'b01:   level_nxt = level_q - CW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Vector storage carries no reset; only occupancy and pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int l = 0; l < LANES; l++) begin
        mem_data[wr_ptr][l] <= in_data[l*WIDTH +: WIDTH];
      end
      mem_op[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      lane_cnt   <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q <= level_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (last_beat) begin
        rd_ptr   <= rd_ptr + PW'(1);
        lane_cnt <= '0;
      end else if (beat) begin
        lane_cnt <= lane_cnt + LW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (level_nxt != '0) begin
      state_nxt = SEND;
    end
  end

  // Outputs are gated to zero while idle so stale FIFO contents never leak.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_op    = '0;
    out_last  = 1'b0;
    out_lane  = lane_cnt;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = mem_data[rd_ptr][lane_cnt];
      out_op    = mem_op[rd_ptr];
      out_last  = lane_is_last;
    end
  end

endmodule

// File: tb/tb_simd_lane_serializer.sv
// Randomised scoreboard bench for simd_lane_serializer: stimulus queues expected
// lane beats, a negedge monitor compares every presented beat against them.
module tb_simd_lane_serializer;

  localparam int LANES = 8;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int LW    = 3;
  localparam int CW    = 2;

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic [LANES*WIDTH-1:0]   in_data;
  logic [2:0]               in_op;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [LW-1:0]            out_lane;
  logic [2:0]               out_op;
  logic                     out_last;
  logic                     overflow;
  logic                     clr_ovf;
  logic [CW-1:0]            level;

  simd_lane_serializer #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_op(in_op), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_op(out_op), .out_last(out_last),
    .overflow(overflow), .clr_ovf(clr_ovf), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               lane;
    logic [2:0]       op;
  } beat_t;

  beat_t                  exp_q[$];
  int                     n_checks = 0;
  int                     n_fail   = 0;
  bit                     pend;
  logic [LANES*WIDTH-1:0] pend_data;
  logic [2:0]             pend_op;
  bit                     ovf_model;
  bit                     ovf_nxt;
  int                     mon_lvl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Vector builders: 0 ADD 2i+11, 1 SUB 100-2i, 2 MUL (i+1)(i+2), 3 DIV 1000/(i+1), 4 EXP 2^i, else random
  function automatic logic [LANES*WIDTH-1:0] mkvec(input int kind);
    logic [LANES*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      case (kind)
        0:       v[i*WIDTH +: WIDTH] = WIDTH'(2*i + 11);
        1:       v[i*WIDTH +: WIDTH] = WIDTH'(100 - 2*i);
        2:       v[i*WIDTH +: WIDTH] = WIDTH'((i+1)*(i+2));
        3:       v[i*WIDTH +: WIDTH] = WIDTH'(1000/(i+1));
        4:       v[i*WIDTH +: WIDTH] = WIDTH'(1 << i);
        default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      endcase
    end
    return v;
  endfunction

  // One clock of stimulus: commit what the previous edge accepted, then
  // drive new inputs and predict whether the coming edge accepts them.
  task automatic step(input bit v, input logic [LANES*WIDTH-1:0] d, input logic [2:0] op,
                      input bit rdy, input bit clr);
    int vecs;
    @(posedge clk);
    #1;
    if (pend) begin
      for (int i = 0; i < LANES; i++)
        exp_q.push_back('{data: pend_data[i*WIDTH +: WIDTH], lane: i, op: pend_op});
      pend = 0;
    end
    ovf_model = ovf_nxt;
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    out_ready = rdy;
    clr_ovf   = clr;
    vecs = (exp_q.size() + LANES - 1) / LANES;
    if (v && vecs < DEPTH) begin
      pend      = 1;
      pend_data = d;
      pend_op   = op;
    end
    if (v && vecs >= DEPTH) ovf_nxt = 1;
    else if (clr)           ovf_nxt = 0;
    else                    ovf_nxt = ovf_model;
  endtask

  // mode 0: ready held high, 1: pattern 1,0,0 repeating, 2: random ready
  task automatic drain(input int mode);
    int g;
    bit r;
    g = 0;
    while ((exp_q.size() > 0 || pend) && g < 300) begin
      if (mode == 0)      r = 1;
      else if (mode == 1) r = (g % 3 == 0);
      else                r = 1'($urandom_range(0, 1));
      step(0, '0, 3'd0, r, 0);
      g++;
    end
    step(0, '0, 3'd0, 1, 0);
    n_checks++;
    if (g >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d beats still pending after %0d cycles", exp_q.size(), g);
    end
  endtask

  task automatic async_reset_now();
    rst       = 1'b0;
    exp_q.delete();
    pend      = 0;
    ovf_model = 0;
    ovf_nxt   = 0;
    in_valid  = 1'b0;
    clr_ovf   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_in_reset", 64'(out_valid), 64'd0);
    end else begin
      mon_lvl = (exp_q.size() + LANES - 1) / LANES;
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("level",     64'(level),     64'(mon_lvl));
      chk("in_ready",  64'(in_ready),  64'(mon_lvl != DEPTH));
      chk("overflow",  64'(overflow),  64'(ovf_model));
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
        chk("out_lane", 64'(out_lane), 64'(exp_q[0].lane));
        chk("out_op",   64'(out_op),   64'(exp_q[0].op));
        chk("out_last", 64'(out_last), 64'(exp_q[0].lane == LANES - 1));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0;
    out_ready = 1'b0; clr_ovf = 1'b0;
    pend = 0; ovf_model = 0; ovf_nxt = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_level",     64'(level),     64'd0);
    chk("rst_overflow",  64'(overflow),  64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_lane",  64'(out_lane),  64'd0);
    chk("rst_out_op",    64'(out_op),    64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single ADD vector, ready held high
    step(1, mkvec(0), 3'b000, 1, 0);
    drain(0);

    // Same vector under 1,0,0 backpressure
    step(1, mkvec(0), 3'b000, 1, 0);
    drain(1);

    // Fill and overflow with ready low
    step(1, mkvec(1), 3'b001, 0, 0);
    step(1, mkvec(2), 3'b010, 0, 0);
    step(1, mkvec(3), 3'b011, 0, 0);
    step(0, '0, 3'd0, 0, 0);
    chk("fill_level",    64'(level),    64'd2);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_overflow", 64'(overflow), 64'd1);
    drain(0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step(0, '0, 3'd0, 1, 1);
    step(0, '0, 3'd0, 1, 0);
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // EXP pushed on the same edge the previous vector's last lane pops
    step(1, mkvec(3), 3'b011, 1, 0);
    repeat (7) step(0, '0, 3'd0, 1, 0);
    step(1, mkvec(4), 3'b100, 1, 0);
    step(0, '0, 3'd0, 1, 0);
    chk("b2b_level", 64'(level),    64'd1);
    chk("b2b_lane",  64'(out_lane), 64'd0);
    chk("b2b_op",    64'(out_op),   64'd4);
    chk("b2b_data",  64'(out_data), 64'd1);
    drain(0);

    // Full FIFO with a concurrent last-lane pop still drops the new vector
    step(1, mkvec(1), 3'b001, 0, 0);
    step(1, mkvec(2), 3'b010, 0, 0);
    repeat (7) step(0, '0, 3'd0, 1, 0);
    step(1, mkvec(4), 3'b100, 1, 0);
    step(0, '0, 3'd0, 1, 0);
    chk("full_pop_drop_ovf", 64'(overflow), 64'd1);
    drain(0);

    // Asynchronous reset after lane 3, overflow still set from above
    step(1, mkvec(2), 3'b010, 1, 0);
    repeat (5) step(0, '0, 3'd0, 1, 0);
    #2;
    async_reset_now();
    #1;
    chk("midrst_valid",    64'(out_valid), 64'd0);
    chk("midrst_level",    64'(level),     64'd0);
    chk("midrst_overflow", 64'(overflow),  64'd0);
    chk("midrst_in_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1, mkvec(0), 3'b000, 1, 0);
    step(0, '0, 3'd0, 1, 0);
    chk("post_rst_lane", 64'(out_lane), 64'd0);
    chk("post_rst_data", 64'(out_data), 64'd11);
    drain(0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 2) == 0), mkvec(9), 3'($urandom_range(0, 4)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    drain(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
